lzc_seq_32: RTL

Sequential leading-zero counter for 32-bit ALU results. It sits beside the combinational zero-flag detector, which collapses a word to one bit. This block expands the word instead: it reports how many leading zeros the word has and where its most-significant set bit is. It scans the operand a fixed number of bits per cycle under a start/done handshake, and is used by normalisation and count-leading-zeros instruction paths.

---
 rtl/lzc_seq_32.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lzc_seq_32.sv
// lzc_seq_32: sequential leading-zero counter for a 32-bit operand.
// The operand is captured into a shift register and scanned from the
// top, BITS_PER_CYCLE bits per clock. The scan stops at the first chunk
// that holds a set bit, or after the last chunk for an all-zero operand.
// cnt/pos/zero are registered and only move on the edge that enters DONE.
//
// Handshake: start is sampled only while busy is low (IDLE or DONE);
// a sampled start captures A on that edge and raises busy from the next
// cycle. busy stays high for exactly the scan cycles, then done pulses
// for one cycle with results valid. start seen while busy is dropped,
// never queued. Holding start high through the done cycle chains the
// next operation with no idle gap.
//
// BITS_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32.
module lzc_seq_32 #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  output logic        busy,
  output logic        done,
  output logic [5:0]  cnt,
  output logic [4:0]  pos,
  output logic        zero,
  output logic [1:0]  dbg_state
);

  localparam int NCHUNK = 32 / BITS_PER_CYCLE;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [5:0]      STEP     = 6'(BITS_PER_CYCLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       shift_q, shift_d;
  logic [5:0]        count_q, count_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [4:0]        pos_q, pos_d;
  logic              zero_q, zero_d;

  logic [BITS_PER_CYCLE-1:0] chunk;
  logic                      chunk_hit;
  logic [5:0]                chunk_lz;
  logic [5:0]                found_cnt;

  // The chunk under inspection is always the top of the shift register.
  assign chunk = shift_q[31 -: BITS_PER_CYCLE];

  // Priority search from the chunk MSB: position of the first set bit.
  always_comb begin
    chunk_hit = 1'b0;
    chunk_lz  = STEP;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (!chunk_hit && chunk[BITS_PER_CYCLE-1-i]) begin
        chunk_hit = 1'b1;
        chunk_lz  = 6'(i);
      end
    end
  end

  // Leading zeros of the whole word when this chunk holds the MSB set bit;
  // never exceeds 31 when chunk_hit is set.
  assign found_cnt = count_q + chunk_lz;

  // Next-state and datapath update for the IDLE/SCAN/DONE controller.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    zero_d  = zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          shift_d = A;
          count_d = 6'd0;
          idx_d   = '0;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SCAN: begin
        if (chunk_hit) begin
          cnt_d   = found_cnt;
          pos_d   = 5'd31 - found_cnt[4:0];
          zero_d  = 1'b0;
          state_d = S_DONE;
        end else if (idx_q == LAST_IDX) begin
          cnt_d   = 6'd32;
          pos_d   = 5'd0;
          zero_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          shift_d = shift_q << BITS_PER_CYCLE;
          count_d = count_q + STEP;
          idx_d   = idx_q + IDX_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= 32'd0;
      count_q <= 6'd0;
      idx_q   <= '0;
      cnt_q   <= 6'd0;
      pos_q   <= 5'd0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      zero_q  <= zero_d;
    end
  end

  assign busy      = (state_q == S_SCAN);
  assign done      = (state_q == S_DONE);
  assign cnt       = cnt_q;
  assign pos       = pos_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;

endmodule
